// File: rtl/input_conditioner_if.sv
// Input conditioner signal bundle: raw async inputs and filter enable in,
// synchronised, debounced levels and edge pulses out.
interface input_conditioner_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] async_in;
    logic                filter_en;
    logic [CHANNELS-1:0] sync_out;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic                changed;

    modport master (
        output async_in,
        output filter_en,
        input  sync_out,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  changed
    );

    modport slave (
        input  async_in,
        input  filter_en,
        output sync_out,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output changed
    );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchroniser chains, per-channel
// debounce counters and registered rise/fall pulses.
module input_conditioner #(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_COUNT = 8
) (
    input logic clk,
    input logic reset,
    input_conditioner_if.slave bus
);
    if (CHANNELS < 1 || SYNC_STAGES < 2 || FILTER_COUNT < 1) begin : g_bad_param
        $error("input_conditioner: illegal parameter value");
    end

    localparam int CW = (FILTER_COUNT > 1) ? $clog2(FILTER_COUNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_COUNT - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_s;
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, fall_q;

    // Stage 0 is only ever read by stage 1 to keep metastability contained.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            unique case (1'b1)
                !bus.filter_en: begin
                    level_d[i] = sync_s[i];
                end
                bus.filter_en && (sync_s[i] == level_q[i]): begin
                    cnt_d[i] = '0;
                end
                bus.filter_en && (sync_s[i] != level_q[i])
                    && (cnt_q[i] == CNT_MAX): begin
                    level_d[i] = sync_s[i];
                end
                default: begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= level_q & ~level_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.sync_out   = sync_s;
    assign bus.level_out  = level_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.changed    = |(rise_q | fall_q);
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: vector table, directed
// corner-case sequences and random stimulus against a sliding-window model.
module tb_input_conditioner;
    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FC = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_conditioner_if #(.CHANNELS(CH)) bus ();

    input_conditioner #(
        .CHANNELS(CH),
        .SYNC_STAGES(SS),
        .FILTER_COUNT(FC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: sync_out is the input sampled SS-1 edges earlier
    // unless a reset edge intervened; a filtered level flips only when the
    // last FC sampled sync values all differ from it with filtering active.
    typedef struct {
        bit            ok;
        logic [CH-1:0] s;
    } samp_t;

    logic [CH-1:0] a_hist[$];
    bit            r_hist[$];
    samp_t         w_q[$];
    logic [CH-1:0] m_sync  = '0;
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_rise  = '0;
    logic [CH-1:0] m_fall  = '0;

    task automatic model_step(input bit rst, input bit fe,
                              input logic [CH-1:0] a);
        logic [CH-1:0] s_prev;
        logic [CH-1:0] old;
        samp_t         e;
        bit            all;
        s_prev = m_sync;
        old    = m_level;
        a_hist.push_front(a);
        r_hist.push_front(rst);
        void'(a_hist.pop_back());
        void'(r_hist.pop_back());
        m_sync = a_hist[SS-1];
        foreach (r_hist[k]) if (r_hist[k]) m_sync = '0;
        e.ok = fe && !rst;
        e.s  = s_prev;
        w_q.push_front(e);
        void'(w_q.pop_back());
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_level[c] = 1'b0;
            end else if (!fe) begin
                m_level[c] = s_prev[c];
            end else begin
                all = 1'b1;
                foreach (w_q[k])
                    if (!w_q[k].ok || w_q[k].s[c] == old[c]) all = 1'b0;
                if (all) m_level[c] = ~old[c];
            end
        end
        m_rise = rst ? '0 : (m_level & ~old);
        m_fall = rst ? '0 : (old & ~m_level);
    endtask

    task automatic cyc(input bit rst, input bit fe, input logic [CH-1:0] a);
        reset         = rst;
        bus.filter_en = fe;
        bus.async_in  = a;
        @(posedge clk);
        model_step(rst, fe, a);
        #1;
        chk("sync_out", 32'(bus.sync_out), 32'(m_sync));
        chk("level_out", 32'(bus.level_out), 32'(m_level));
        chk("rise_pulse", 32'(bus.rise_pulse), 32'(m_rise));
        chk("fall_pulse", 32'(bus.fall_pulse), 32'(m_fall));
        chk("changed", 32'(bus.changed), 32'(|(m_rise | m_fall)));
    endtask

    typedef struct {
        bit            rst;
        logic [CH-1:0] a;
        logic [CH-1:0] sync;
        logic [CH-1:0] level;
        logic [CH-1:0] rise;
        bit            chg;
    } vec_t;

    vec_t vt[$];

    initial begin
        int n_sync, n_lvl, n_p, lat, n_fall, n_rise, n_both;
        logic prev_s;
        logic [CH-1:0] a;
        vec_t v;

        for (int k = 0; k < SS; k++) begin
            a_hist.push_back('0);
            r_hist.push_back(1'b1);
        end
        for (int k = 0; k < FC; k++) begin
            samp_t e;
            e.ok = 1'b0;
            e.s  = '0;
            w_q.push_back(e);
        end

        for (int k = 0; k < 3; k++) begin
            v = '{rst: 1'b1, a: 4'hF, sync: 4'h0, level: 4'h0,
                  rise: 4'h0, chg: 1'b0};
            vt.push_back(v);
        end
        for (int ed = 1; ed <= 11; ed++) begin
            v.rst   = 1'b0;
            v.a     = 4'hF;
            v.sync  = (ed >= 2) ? 4'hF : 4'h0;
            v.level = (ed >= 10) ? 4'hF : 4'h0;
            v.rise  = (ed == 10) ? 4'hF : 4'h0;
            v.chg   = (ed == 10);
            vt.push_back(v);
        end

        foreach (vt[k]) begin
            cyc(vt[k].rst, 1'b1, vt[k].a);
            chk("tbl_sync", 32'(bus.sync_out), 32'(vt[k].sync));
            chk("tbl_level", 32'(bus.level_out), 32'(vt[k].level));
            chk("tbl_rise", 32'(bus.rise_pulse), 32'(vt[k].rise));
            chk("tbl_fall", 32'(bus.fall_pulse), 32'h0);
            chk("tbl_changed", 32'(bus.changed), 32'(vt[k].chg));
        end

        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 4'h0);

        n_sync = 0; n_lvl = 0; n_p = 0;
        for (int k = 0; k < 22; k++) begin
            cyc(1'b0, 1'b1, (k < 7) ? 4'h1 : 4'h0);
            if (bus.sync_out[0]) n_sync++;
            if (bus.level_out[0]) n_lvl++;
            if (bus.rise_pulse[0] || bus.fall_pulse[0]) n_p++;
        end
        chk("glitch_sync_width", 32'(n_sync), 32'd7);
        chk("glitch_level", 32'(n_lvl), 32'd0);
        chk("glitch_pulses", 32'(n_p), 32'd0);

        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            cyc(1'b0, 1'b1, 4'h1);
            if (bus.level_out[0]) begin
                lat = k;
                chk("rise_with_level", 32'(bus.rise_pulse[0]), 32'd1);
            end
        end
        chk("rise_latency", 32'(lat), 32'd10);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 4'h1);
        lat = 0; n_fall = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b1, 4'h0);
            if (bus.fall_pulse[0]) begin
                n_fall++;
                if (lat == 0) lat = k;
            end
        end
        chk("fall_latency", 32'(lat), 32'd10);
        chk("fall_width", 32'(n_fall), 32'd1);

        n_rise = 0; n_fall = 0; n_both = 0;
        a = 4'h0;
        for (int k = 0; k < 16; k++) begin
            a[2] = ~a[2];
            prev_s = bus.sync_out[2];
            cyc(1'b0, 1'b0, a);
            chk("bypass_delay", 32'(bus.level_out[2]), 32'(prev_s));
            if (bus.rise_pulse[2]) n_rise++;
            if (bus.fall_pulse[2]) n_fall++;
            if (bus.rise_pulse[2] && bus.fall_pulse[2]) n_both++;
        end
        chk("bypass_rises", 32'(n_rise > 5), 32'd1);
        chk("bypass_falls", 32'(n_fall > 5), 32'd1);
        chk("bypass_both", 32'(n_both), 32'd0);
        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 4'h0);

        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 4'h8);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1, 4'h2);
            if (k == 9) chk("conc_early", 32'(bus.changed), 32'd0);
        end
        chk("conc_rise", 32'(bus.rise_pulse), 32'h2);
        chk("conc_fall", 32'(bus.fall_pulse), 32'h8);
        chk("conc_changed", 32'(bus.changed), 32'd1);

        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 4'h0);
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 4'h1);
        cyc(1'b1, 1'b1, 4'h1);
        chk("rst_mid_sync", 32'(bus.sync_out), 32'h0);
        chk("rst_mid_level", 32'(bus.level_out), 32'h0);
        chk("rst_mid_changed", 32'(bus.changed), 32'd0);
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            cyc(1'b0, 1'b1, 4'h1);
            if (bus.level_out[0]) lat = k;
        end
        chk("rst_mid_latency", 32'(lat), 32'd10);

        a = 4'h0;
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            bit fe;
            len = $urandom_range(1, 14);
            fe  = ($urandom_range(0, 7) != 0);
            a   = a ^ CH'($urandom_range(0, 15));
            for (int k = 0; k < len; k++) begin
                cyc(($urandom_range(0, 49) == 0), fe, a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent asynchronous input channels; SHALL be >= 1.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flops per synchroniser chain; SHALL be >= 2.
REQ-003 Parameter FILTER_COUNT, default 8: consecutive stable samples required to accept a level change; SHALL be >= 1.
REQ-004 An illegal parameter value SHALL cause an elaboration-time error.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 async_in  input  CHANNELS  asynchronous inputs, one bit per channel.
REQ-008 filter_en  input  1  1 = debounce active; 0 = bypass debounce. Synchronous to clk.
REQ-009 sync_out  output  CHANNELS  raw synchronised inputs, last stage of each chain.
REQ-010 level_out  output  CHANNELS  debounced level per channel.
REQ-011 rise_pulse  output  CHANNELS  one-cycle pulse on a 0->1 change of level_out.
REQ-012 fall_pulse  output  CHANNELS  one-cycle pulse on a 1->0 change of level_out.
REQ-013 changed  output  1  OR-reduction of rise_pulse | fall_pulse; combinational from registers only.

Function
REQ-014 Each channel SHALL have its own SYNC_STAGES-deep shift chain: async_in[i] enters stage 1 and sync_out[i] is the last stage. Latency is SYNC_STAGES edges.
REQ-015 No logic other than the next chain stage SHALL read stage 1 of any chain.
REQ-016 Each channel SHALL have a counter of width max(1, clog2(FILTER_COUNT)).
REQ-017 Per edge with filter_en=1: if sync_out[i]==level_out[i], cnt<=0; else if cnt==FILTER_COUNT-1, level_out[i]<=sync_out[i] and cnt<=0; else cnt<=cnt+1.
REQ-018 Accepted-change latency with filter_en=1 SHALL be SYNC_STAGES+FILTER_COUNT edges from the first edge that samples the new async level.
REQ-019 A sync_out deviation shorter than FILTER_COUNT consecutive samples SHALL leave level_out unchanged, clear cnt and produce no pulse.
REQ-020 With filter_en=0: level_out[i]<=sync_out[i] on every edge, and all counters SHALL be held at 0.
REQ-021 When filter_en goes 1->0, any partial count SHALL be discarded. When it goes 0->1, counting SHALL start from 0.
REQ-022 rise_pulse[i]/fall_pulse[i] SHALL be registered and asserted in the same cycle that level_out[i] first shows the new value, for exactly one cycle.
REQ-023 rise_pulse[i] and fall_pulse[i] SHALL never be high together.
REQ-024 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous pulses.
REQ-025 Counters SHALL never exceed FILTER_COUNT-1 or wrap.

Reset
REQ-026 While reset=1 at an edge: all chain stages, counters, level_out, rise_pulse and fall_pulse SHALL be 0, so changed=0; async_in is ignored.
REQ-027 Reset asserted mid-count SHALL clear the count. After release, counting restarts from 0.
REQ-028 A channel that is high at reset release SHALL produce a normal rise_pulse after SYNC_STAGES+FILTER_COUNT edges.

Verification (defaults CHANNELS=4, SYNC_STAGES=2, FILTER_COUNT=8, filter_en=1 unless stated)
REQ-029 Reset behaviour: reset=1 for 3 edges with async_in=4'hF -> all outputs 0. After release: sync_out=4'hF after edge 2, level_out=4'hF and rise_pulse=4'hF after edge 10, pulses 0 after edge 11, changed=1 for that one cycle only.
REQ-030 Glitch rejection: async_in[0] high for 7 cycles then low -> sync_out[0] shows a 7-cycle pulse; level_out[0] stays 0; rise_pulse and fall_pulse stay 0.
REQ-031 Exact latency: async_in[0] 0->1 held -> level_out[0] rises after exactly edge 10. A later 1->0 held -> fall_pulse[0] is high for one cycle after edge 10 from that change.
REQ-032 Bypass: filter_en=0 and async_in[2] toggling every cycle -> level_out[2] equals sync_out[2] delayed one edge, with alternating single-cycle rise_pulse[2]/fall_pulse[2] and never both high.
REQ-033 Concurrent channels: ch1 0->1 and ch3 1->0 on the same edge -> after 10 edges rise_pulse=4'h2 and fall_pulse=4'h8 in the same cycle, changed=1.
REQ-034 Reset mid-count: ch0 counter at 5, reset asserted for one edge -> all state 0. After release with async_in[0] still 1, level_out[0] rises 10 edges later.
